// File: rtl/match_controller.sv
// rtl/match_controller.sv - round and match flow sequencer for the 2-player fighter
//
// Purpose:
//   Owns the round/match state machine. Converts resolver hit pulses into HP
//   loss, runs the round clock, decides KO / timeout / round and match winner,
//   and gates the hit resolver and player logic. Every state change happens on
//   a clk edge with SCEN=1. round_reset is the one exception: it clears on the
//   next clk edge whether or not SCEN is high.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   SCEN                  one-cycle frame tick
//   start_btn             start request (edge-detected upstream)
//   p1/p2_hit_event       resolver hit pulses; p1/p2_hit_heavy selects damage
//   resolver_en           high only in FIGHT
//   players_freeze        high in every state except FIGHT
//   round_reset           one-clock pulse that sends players back to spawn
//   p1_hp, p2_hp          current HP
//   p1_rounds, p2_rounds  round wins (saturate at 3)
//   round_time            seconds remaining in the round
//   state_code            0 TITLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER
//   winner                0 none, 1 P1, 2 P2, 3 draw
module match_controller #(
  parameter int HP_MAX           = 100,
  parameter int DMG_LIGHT        = 8,
  parameter int DMG_HEAVY        = 15,
  parameter int ROUNDS_TO_WIN    = 2,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int ROUND_SECONDS    = 60,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int KO_HOLD_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       start_btn,
  input  logic       p1_hit_event,
  input  logic       p1_hit_heavy,
  input  logic       p2_hit_event,
  input  logic       p2_hit_heavy,
  output logic       resolver_en,
  output logic       players_freeze,
  output logic       round_reset,
  output logic [6:0] p1_hp,
  output logic [6:0] p2_hp,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [6:0] round_time,
  output logic [2:0] state_code,
  output logic [1:0] winner
);

  if (HP_MAX >= 128) begin : g_bad_hp
    $error("HP_MAX must be below 128");
  end
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 3) begin : g_bad_rounds
    $error("ROUNDS_TO_WIN must be 1..3");
  end

  typedef enum logic [2:0] {
    S_TITLE      = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_ROUND_END  = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_e;

  // One frame counter is shared by the countdown and the KO hold, so it is
  // sized for the longer of the two.
  localparam int CNT_MAX = (COUNTDOWN_FRAMES > KO_HOLD_FRAMES) ? COUNTDOWN_FRAMES : KO_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUB_W   = $clog2(FRAMES_PER_SEC + 1);

  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] KO_LAST  = CNT_W'(KO_HOLD_FRAMES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]       HP_FULL  = 7'(HP_MAX);
  localparam logic [6:0]       DMG_L    = 7'(DMG_LIGHT);
  localparam logic [6:0]       DMG_H    = 7'(DMG_HEAVY);
  localparam logic [6:0]       T_FULL   = 7'(ROUND_SECONDS);
  localparam logic [1:0]       R_WIN    = 2'(ROUNDS_TO_WIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [6:0]       hp1_q, hp1_d, hp2_q, hp2_d, time_q, time_d;
  logic [1:0]       r1_q, r1_d, r2_q, r2_d, win_q, win_d;
  logic             rr_q, rr_d;

  logic [6:0] p1_dmg, p2_dmg, hp1_new, hp2_new, time_new;
  logic [1:0] win_new;

  // Damage larger than the remaining HP leaves the player at 0.
  function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
    return (a > b) ? (a - b) : 7'd0;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_TITLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      hp1_q   <= HP_FULL;
      hp2_q   <= HP_FULL;
      time_q  <= T_FULL;
      r1_q    <= 2'd0;
      r2_q    <= 2'd0;
      win_q   <= 2'd0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      hp1_q   <= hp1_d;
      hp2_q   <= hp2_d;
      time_q  <= time_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    hp1_d    = hp1_q;
    hp2_d    = hp2_q;
    time_d   = time_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    win_d    = win_q;
    rr_d     = 1'b0;   // pulse drops on the next edge regardless of SCEN
    p1_dmg   = p1_hit_heavy ? DMG_H : DMG_L;
    p2_dmg   = p2_hit_heavy ? DMG_H : DMG_L;
    hp1_new  = hp1_q;
    hp2_new  = hp2_q;
    time_new = time_q;
    win_new  = 2'd0;

    if (SCEN) begin
      case (state_q)
        S_TITLE: begin
          if (start_btn) begin
            state_d = S_COUNTDOWN;
            cnt_d   = '0;
            hp1_d   = HP_FULL;
            hp2_d   = HP_FULL;
            time_d  = T_FULL;
            r1_d    = 2'd0;
            r2_d    = 2'd0;
            win_d   = 2'd0;
            rr_d    = 1'b1;
          end
        end

        S_COUNTDOWN: begin
          if (cnt_q == CD_LAST) begin
            state_d = S_FIGHT;
            cnt_d   = '0;
            sub_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_FIGHT: begin
          hp1_new = p1_hit_event ? sat_sub(hp1_q, p1_dmg) : hp1_q;
          hp2_new = p2_hit_event ? sat_sub(hp2_q, p2_dmg) : hp2_q;
          if (sub_q == SUB_LAST) begin
            sub_d    = '0;
            time_new = (time_q != 7'd0) ? (time_q - 7'd1) : 7'd0;
          end else begin
            sub_d    = sub_q + 1'b1;
          end
          hp1_d  = hp1_new;
          hp2_d  = hp2_new;
          time_d = time_new;

          // Exit decision uses this frame's HP and timer; KO outranks timeout.
          if (hp1_new == 7'd0 && hp2_new == 7'd0)  win_new = 2'd3;
          else if (hp1_new == 7'd0)                win_new = 2'd2;
          else if (hp2_new == 7'd0)                win_new = 2'd1;
          else if (time_new == 7'd0) begin
            if (hp1_new > hp2_new)                 win_new = 2'd1;
            else if (hp2_new > hp1_new)            win_new = 2'd2;
            else                                   win_new = 2'd3;
          end

          if (win_new != 2'd0) begin
            state_d = S_ROUND_END;
            cnt_d   = '0;
            win_d   = win_new;
            if (win_new == 2'd1 && r1_q != 2'd3) r1_d = r1_q + 2'd1;
            if (win_new == 2'd2 && r2_q != 2'd3) r2_d = r2_q + 2'd1;
          end
        end

        S_ROUND_END: begin
          if (cnt_q == KO_LAST) begin
            cnt_d = '0;
            if (r1_q == R_WIN || r2_q == R_WIN) begin
              state_d = S_MATCH_OVER;
            end else begin
              state_d = S_COUNTDOWN;
              hp1_d   = HP_FULL;
              hp2_d   = HP_FULL;
              time_d  = T_FULL;
              win_d   = 2'd0;
              rr_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_MATCH_OVER: begin
          // Returning to TITLE applies the title-entry reset at once; a fresh
          // press is still required to start the next match.
          if (start_btn) begin
            state_d = S_TITLE;
            cnt_d   = '0;
            hp1_d   = HP_FULL;
            hp2_d   = HP_FULL;
            time_d  = T_FULL;
            r1_d    = 2'd0;
            r2_d    = 2'd0;
            win_d   = 2'd0;
            rr_d    = 1'b1;
          end
        end

        default: state_d = S_TITLE;
      endcase
    end
  end

  always_comb begin
    resolver_en    = (state_q == S_FIGHT);
    players_freeze = (state_q != S_FIGHT);
    round_reset    = rr_q;
    p1_hp          = hp1_q;
    p2_hp          = hp2_q;
    p1_rounds      = r1_q;
    p2_rounds      = r2_q;
    round_time     = time_q;
    state_code     = state_q;
    winner         = win_q;
  end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed-vector bench for match_controller
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset_n, SCEN, start_btn;
  logic       p1_hit_event, p1_hit_heavy, p2_hit_event, p2_hit_heavy;
  logic       resolver_en, players_freeze, round_reset;
  logic [6:0] p1_hp, p2_hp, round_time;
  logic [1:0] p1_rounds, p2_rounds, winner;
  logic [2:0] state_code;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_cnt   = 0;

  always #5 clk = ~clk;

  match_controller dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .SCEN           (SCEN),
    .start_btn      (start_btn),
    .p1_hit_event   (p1_hit_event),
    .p1_hit_heavy   (p1_hit_heavy),
    .p2_hit_event   (p2_hit_event),
    .p2_hit_heavy   (p2_hit_heavy),
    .resolver_en    (resolver_en),
    .players_freeze (players_freeze),
    .round_reset    (round_reset),
    .p1_hp          (p1_hp),
    .p2_hp          (p2_hp),
    .p1_rounds      (p1_rounds),
    .p2_rounds      (p2_rounds),
    .round_time     (round_time),
    .state_code     (state_code),
    .winner         (winner)
  );

  // Counts clocks during which round_reset is high (pulse count x width).
  always @(negedge clk) if (round_reset === 1'b1) rr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic scen, input logic st,
                      input logic a_e, input logic a_h, input logic b_e, input logic b_h);
    SCEN = scen; start_btn = st;
    p1_hit_event = a_e; p1_hit_heavy = a_h;
    p2_hit_event = b_e; p2_hit_heavy = b_h;
    @(posedge clk);
    #2;
  endtask

  // One frame: a SCEN clock, then a non-SCEN clock with the same hit inputs held.
  task automatic frame(input logic st,
                       input logic a_e, input logic a_h, input logic b_e, input logic b_h);
    step(1'b1, st, a_e, a_h, b_e, b_h);
    step(1'b0, 1'b0, a_e, a_h, b_e, b_h);
  endtask

  initial begin
    reset_n = 1'b0; SCEN = 1'b0; start_btn = 1'b0;
    p1_hit_event = 1'b0; p1_hit_heavy = 1'b0; p2_hit_event = 1'b0; p2_hit_heavy = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    check("rst_state", state_code, 0);
    check("rst_p1_hp", p1_hp, 100);
    check("rst_p2_hp", p2_hp, 100);
    check("rst_rounds", {p1_rounds, p2_rounds}, 0);
    check("rst_time", round_time, 60);
    check("rst_winner", winner, 0);
    check("rst_res_en", resolver_en, 0);
    check("rst_freeze", players_freeze, 1);
    check("rst_rr", round_reset, 0);
    reset_n = 1'b1;

    // Start press: ignored without SCEN, accepted with it.
    step(0, 1, 0, 0, 0, 0);
    check("start_no_scen", state_code, 0);
    step(1, 1, 0, 0, 0, 0);
    check("start_state", state_code, 1);
    check("start_rr_high", round_reset, 1);
    step(0, 0, 0, 0, 0, 0);
    check("start_rr_low", round_reset, 0);

    // Countdown with hits asserted: no damage, FIGHT on the 180th SCEN.
    repeat (179) frame(0, 1, 1, 1, 0);
    check("cd179_state", state_code, 1);
    check("cd179_res_en", resolver_en, 0);
    check("cd_p1_hp", p1_hp, 100);
    check("cd_p2_hp", p2_hp, 100);
    frame(0, 0, 0, 0, 0);
    check("cd180_state", state_code, 2);
    check("cd180_res_en", resolver_en, 1);
    check("fight_freeze", players_freeze, 0);
    check("rr_count_1", rr_cnt, 1);

    // Seven heavy hits on P2: 100-90=10, then KO.
    repeat (6) frame(0, 0, 0, 1, 1);
    check("dmg6_p2_hp", p2_hp, 10);
    check("dmg6_p1_hp", p1_hp, 100);
    check("dmg6_state", state_code, 2);
    frame(0, 0, 0, 1, 1);
    check("ko_p2_hp", p2_hp, 0);
    check("ko_state", state_code, 3);
    check("ko_winner", winner, 1);
    check("ko_p1_rounds", p1_rounds, 1);
    check("ko_p2_rounds", p2_rounds, 0);
    check("ko_res_en", resolver_en, 0);

    // KO hold: hits ignored, replay after 120 frames.
    repeat (119) frame(0, 1, 1, 1, 1);
    check("hold_state", state_code, 3);
    check("hold_p1_hp", p1_hp, 100);
    check("hold_p2_hp", p2_hp, 0);
    frame(0, 0, 0, 0, 0);
    check("r2_state", state_code, 1);
    check("r2_p2_hp", p2_hp, 100);
    check("r2_winner", winner, 0);
    check("r2_time", round_time, 60);
    check("rr_count_2", rr_cnt, 2);
    repeat (180) frame(0, 0, 0, 0, 0);
    check("r2_fight", state_code, 2);

    // Trades down to 8/8 (4 heavy + 4 light), then a double light KO.
    repeat (4) frame(0, 1, 1, 1, 1);
    check("trade_p1_40", p1_hp, 40);
    repeat (4) frame(0, 1, 0, 1, 0);
    check("trade_p1_8", p1_hp, 8);
    check("trade_p2_8", p2_hp, 8);
    frame(0, 1, 0, 1, 0);
    check("draw_p1_hp", p1_hp, 0);
    check("draw_p2_hp", p2_hp, 0);
    check("draw_state", state_code, 3);
    check("draw_winner", winner, 3);
    check("draw_p1_rounds", p1_rounds, 1);
    check("draw_p2_rounds", p2_rounds, 0);
    repeat (120) frame(0, 0, 0, 0, 0);
    check("replay_state", state_code, 1);
    check("rr_count_3", rr_cnt, 3);
    repeat (180) frame(0, 0, 0, 0, 0);
    check("r3_fight", state_code, 2);

    // Timeout round: P1 light, P2 heavy on the first frame -> 92 vs 85.
    frame(0, 1, 0, 1, 1);
    check("to_p1_hp", p1_hp, 92);
    check("to_p2_hp", p2_hp, 85);
    repeat (59) frame(0, 0, 0, 0, 0);
    check("to_time_59", round_time, 59);
    repeat (3539) frame(0, 0, 0, 0, 0);
    check("to_time_1", round_time, 1);
    check("to_still_fight", state_code, 2);
    frame(0, 0, 0, 0, 0);
    check("to_time_0", round_time, 0);
    check("to_state", state_code, 3);
    check("to_winner", winner, 1);
    check("to_p1_rounds", p1_rounds, 2);
    repeat (120) frame(0, 0, 0, 0, 0);
    check("mo_state", state_code, 4);
    check("mo_winner", winner, 1);
    check("mo_p1_rounds", p1_rounds, 2);

    // MATCH_OVER -> TITLE only on start with SCEN.
    frame(0, 0, 0, 0, 0);
    check("mo_hold", state_code, 4);
    step(0, 1, 0, 0, 0, 0);
    check("mo_no_scen", state_code, 4);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("title_state", state_code, 0);
    check("title_p1_rounds", p1_rounds, 0);
    check("title_p2_rounds", p2_rounds, 0);
    check("title_winner", winner, 0);
    check("title_p1_hp", p1_hp, 100);
    check("rr_count_4", rr_cnt, 4);
    frame(0, 0, 0, 0, 0);
    check("title_no_restart", state_code, 0);

    // Async reset mid-FIGHT with p1_hp=40.
    frame(1, 0, 0, 0, 0);
    check("m2_state", state_code, 1);
    check("rr_count_5", rr_cnt, 5);
    repeat (180) frame(0, 0, 0, 0, 0);
    repeat (4) frame(0, 1, 1, 0, 0);
    check("m2_p1_hp", p1_hp, 40);
    check("m2_fight", state_code, 2);
    reset_n = 1'b0;
    #1;
    check("arst_state", state_code, 0);
    check("arst_p1_hp", p1_hp, 100);
    check("arst_res_en", resolver_en, 0);
    check("arst_freeze", players_freeze, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
